// File: rtl/riscv_defines.sv
// ----------------------------------------------------------------------------
// riscv_defines
// Shared core definitions used by the CSR debug initiator:
//   csr_op_t                - CSR access operation (NONE = read only)
//   dbg_csr_state_t         - debug CSR initiator FSM states
//   DBG_CSR_TIMEOUT_DEFAULT - default halt-wait timeout in cycles
// ----------------------------------------------------------------------------
package riscv_defines;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    IDLE,
    HALT_WAIT,
    ACCESS,
    RESP
  } dbg_csr_state_t;

  localparam int unsigned DBG_CSR_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/riscv_csr_debug_initiator.sv
// ----------------------------------------------------------------------------
// riscv_csr_debug_initiator
// Debug-side initiator for the core's CSR access port. Accepts one CSR
// read/write/set/clear request from the debug bus, halts the pipeline, drives
// a single access cycle into the CSR file and returns the pre-access value.
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   dbg_req_i/op/addr/wdata    debug request (sampled only in IDLE)
//   dbg_gnt_o                  request accepted this cycle (IDLE only)
//   dbg_rvalid_o/rdata/err     one-cycle response; err = halt timed out
//   stall_req_o, stalled_i     pipeline halt handshake
//   csr_access_o/addr/wdata/op CSR port drive (access strobe only in ACCESS)
//   csr_rdata_i                combinational CSR read data
// ----------------------------------------------------------------------------
module riscv_csr_debug_initiator
  import riscv_defines::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBG_CSR_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        dbg_req_i,
  input  csr_op_t     dbg_op_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,

  output logic        stall_req_o,
  input  logic        stalled_i,

  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output csr_op_t     csr_op_o,
  input  logic [31:0] csr_rdata_i
);

  // Counter wide enough to hold TIMEOUT_CYCLES; at least one bit so the
  // timeout-disabled configuration still elaborates.
  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  dbg_csr_state_t    state_q, state_d;
  csr_op_t           op_q,    op_d;
  logic [11:0]       addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q,   err_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    dbg_gnt_o    = 1'b0;
    dbg_rvalid_o = 1'b0;
    dbg_rdata_o  = '0;
    dbg_err_o    = 1'b0;
    stall_req_o  = 1'b0;
    csr_access_o = 1'b0;
    csr_op_o     = CSR_OP_NONE;

    case (state_q)
      IDLE: begin
        dbg_gnt_o = dbg_req_i;
        if (dbg_req_i) begin
          op_d    = dbg_op_i;
          addr_d  = dbg_addr_i;
          wdata_d = dbg_wdata_i;
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = HALT_WAIT;
        end
      end

      HALT_WAIT: begin
        stall_req_o = 1'b1;
        // A halt arriving in the timeout cycle still wins.
        if (stalled_i) begin
          state_d = ACCESS;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACCESS: begin
        // The CSR file updates on the same edge that captures rdata, so the
        // captured value is the pre-access one.
        stall_req_o  = 1'b1;
        csr_access_o = 1'b1;
        csr_op_o     = op_q;
        rdata_d      = csr_rdata_i;
        state_d      = RESP;
      end

      RESP: begin
        dbg_rvalid_o = 1'b1;
        dbg_err_o    = err_q;
        dbg_rdata_o  = err_q ? '0 : rdata_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Address and operand stay on the port at all times; only the strobe and op
  // qualify an access.
  assign csr_addr_o  = addr_q;
  assign csr_wdata_o = wdata_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= CSR_OP_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
